// File: rtl/latch_bank.sv
// latch_bank: CHANNELS independent WIDTH-bit storage words, each selectable between level-enabled
// and enable-edge capture, with complement outputs, change pulse and saturating load counter. Rev 1.0
`default_nettype none

module latch_bank #(
    parameter int               WIDTH       = 8,
    parameter int               CHANNELS    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       clr,
    input  logic                      cnt_clr,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] q_n,
    output logic [CHANNELS-1:0]       upd,
    output logic [CHANNELS*CNT_W-1:0] load_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] q_reg;
        logic [WIDTH-1:0] q_next;
        logic [CNT_W-1:0] cnt;
        logic             en_prev;
        logic             upd_reg;
        logic             load;

        // en_prev tracks en in both modes so a mode switch never fabricates a rising edge
        assign load = mode[i] ? (en[i] & ~en_prev) : en[i];

        always_comb begin
            q_next = q_reg;
            if (clr[i]) begin
                q_next = RESET_VALUE;
            end else if (load) begin
                q_next = d[i*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_reg   <= RESET_VALUE;
                en_prev <= 1'b0;
                upd_reg <= 1'b0;
                cnt     <= '0;
            end else begin
                q_reg   <= q_next;
                en_prev <= en[i];
                upd_reg <= (q_next != q_reg);
                // clr overrides load, so a cleared cycle is not counted
                if (cnt_clr) begin
                    cnt <= '0;
                end else if (load && !clr[i] && (cnt != CNT_MAX)) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign q[i*WIDTH +: WIDTH]        = q_reg;
        assign q_n[i*WIDTH +: WIDTH]      = ~q_reg;
        assign upd[i]                     = upd_reg;
        assign load_cnt[i*CNT_W +: CNT_W] = cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_latch_bank.sv
// tb_latch_bank: vector table with scoreboard for the default bank, plus a 2-bit-counter instance
// for saturation and hand-written reset sequences. Rev 1.0
`default_nettype none

module tb_latch_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d = '0;
    logic [3:0]  en = '0, mode = '0, clr = '0;
    logic        cnt_clr = 1'b0;
    logic [31:0] q, q_n, load_cnt;
    logic [3:0]  upd;

    logic [7:0]  s_d = '0;
    logic        s_en = 1'b0, s_mode = 1'b0, s_clr = 1'b0, s_cnt_clr = 1'b0;
    logic [7:0]  s_q, s_q_n;
    logic        s_upd;
    logic [1:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    latch_bank #(.WIDTH(8), .CHANNELS(4), .RESET_VALUE(8'h00), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
        .q(q), .q_n(q_n), .upd(upd), .load_cnt(load_cnt)
    );

    latch_bank #(.WIDTH(8), .CHANNELS(1), .RESET_VALUE(8'h00), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .d(s_d), .en(s_en), .mode(s_mode), .clr(s_clr),
        .cnt_clr(s_cnt_clr), .q(s_q), .q_n(s_q_n), .upd(s_upd), .load_cnt(s_cnt)
    );

    typedef struct {
        int         ch;
        logic [7:0] d;
        logic       en, md, cl, cc;
        logic [7:0] eq;
        logic       eu;
        logic [7:0] ec;
    } vec_t;

    typedef struct {
        int         ch;
        logic [7:0] q;
        logic [3:0] upd;
        logic [7:0] cnt;
    } exp_t;

    vec_t vt[24];
    exp_t sb[$];
    logic [1:0] sat_exp[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        //      ch  d      en md cl cc  q      upd cnt
        vt[0]  = '{0, 8'hA5, 1, 0, 0, 0, 8'hA5, 1, 8'd1};
        vt[1]  = '{0, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 8'd1};
        vt[2]  = '{1, 8'h11, 1, 0, 0, 0, 8'h11, 1, 8'd1};
        vt[3]  = '{1, 8'h11, 1, 0, 0, 0, 8'h11, 0, 8'd2};
        vt[4]  = '{1, 8'h22, 1, 0, 0, 0, 8'h22, 1, 8'd3};
        vt[5]  = '{1, 8'h33, 0, 0, 0, 0, 8'h22, 0, 8'd3};
        vt[6]  = '{2, 8'h40, 1, 1, 0, 0, 8'h40, 1, 8'd1};
        vt[7]  = '{2, 8'h41, 1, 1, 0, 0, 8'h40, 0, 8'd1};
        vt[8]  = '{2, 8'h42, 1, 1, 0, 0, 8'h40, 0, 8'd1};
        vt[9]  = '{2, 8'h43, 1, 1, 0, 0, 8'h40, 0, 8'd1};
        vt[10] = '{2, 8'h44, 0, 1, 0, 0, 8'h40, 0, 8'd1};
        vt[11] = '{2, 8'h45, 1, 1, 0, 0, 8'h45, 1, 8'd2};
        vt[12] = '{2, 8'h46, 0, 1, 0, 0, 8'h45, 0, 8'd2};
        vt[13] = '{2, 8'h50, 1, 0, 0, 0, 8'h50, 1, 8'd3};
        vt[14] = '{2, 8'h51, 1, 1, 0, 0, 8'h50, 0, 8'd3};
        vt[15] = '{2, 8'h52, 1, 1, 0, 0, 8'h50, 0, 8'd3};
        vt[16] = '{2, 8'h53, 0, 1, 0, 0, 8'h50, 0, 8'd3};
        vt[17] = '{2, 8'h54, 1, 1, 0, 0, 8'h54, 1, 8'd4};
        vt[18] = '{3, 8'h5A, 1, 0, 0, 0, 8'h5A, 1, 8'd1};
        vt[19] = '{3, 8'h77, 1, 0, 1, 0, 8'h00, 1, 8'd1};
        vt[20] = '{3, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'd2};
        vt[21] = '{3, 8'h99, 0, 0, 1, 0, 8'h00, 0, 8'd2};
        vt[22] = '{1, 8'h66, 1, 0, 0, 1, 8'h66, 1, 8'd0};
        vt[23] = '{1, 8'h66, 1, 0, 0, 0, 8'h66, 0, 8'd1};
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;

        // reset held across clock edges with loads requested everywhere
        d  = {4{8'hA5}};
        en = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q",   q,        32'h0000_0000);
        chk("reset_q_n", q_n,      32'hFFFF_FFFF);
        chk("reset_upd", {28'd0, upd}, 32'd0);
        chk("reset_cnt", load_cnt, 32'd0);
        chk("reset_sat_cnt", {30'd0, s_cnt}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            exp_t e;
            d            = {4{vt[i].d}};
            en           = '0;
            clr          = '0;
            en[vt[i].ch]   = vt[i].en;
            mode[vt[i].ch] = vt[i].md;
            clr[vt[i].ch]  = vt[i].cl;
            cnt_clr      = vt[i].cc;
            e.ch  = vt[i].ch;
            e.q   = vt[i].eq;
            e.upd = 4'(vt[i].eu) << vt[i].ch;
            e.cnt = vt[i].ec;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_q", i),   {24'd0, q[e.ch*8 +: 8]},        {24'd0, e.q});
                chk($sformatf("v%0d_q_n", i), {24'd0, q_n[e.ch*8 +: 8]},      {24'd0, ~e.q});
                chk($sformatf("v%0d_upd", i), {28'd0, upd},                   {28'd0, e.upd});
                chk($sformatf("v%0d_cnt", i), {24'd0, load_cnt[e.ch*8 +: 8]}, {24'd0, e.cnt});
            end
            @(negedge clk);
        end
        en      = '0;
        clr     = '0;
        cnt_clr = 1'b0;

        // 2-bit counter saturation in level mode
        for (int k = 0; k < 6; k++) begin
            s_en = 1'b1;
            s_d  = 8'(8'h10 + k);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_cnt", k), {30'd0, s_cnt}, {30'd0, sat_exp[k]});
            chk($sformatf("sat%0d_q", k),   {24'd0, s_q},   {24'd0, 8'(8'h10 + k)});
            @(negedge clk);
        end
        s_cnt_clr = 1'b1;
        s_d       = 8'h20;
        @(posedge clk);
        #1;
        chk("sat_cntclr_load", {30'd0, s_cnt}, 32'd0);
        chk("sat_cntclr_q",    {24'd0, s_q},   32'h20);
        @(negedge clk);
        s_cnt_clr = 1'b0;

        // asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_q",       q,        32'h0000_0000);
        chk("async_q_n",     q_n,      32'hFFFF_FFFF);
        chk("async_upd",     {28'd0, upd}, 32'd0);
        chk("async_cnt",     load_cnt, 32'd0);
        chk("async_sat_cnt", {30'd0, s_cnt}, 32'd0);
        chk("async_sat_q",   {24'd0, s_q},   32'd0);
        @(negedge clk);
        s_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
